s1_scatter: RTL

S1_SCATTER -- requirements
Module: s1_scatter

---
 rtl/s1_scatter.sv | 100 ++++++++++
 1 files changed

// File: rtl/s1_scatter.sv
// Word scatter into four single-entry output lanes, with per-packet lane lock and broadcast.
// Lane select and broadcast are sampled at packet start and held until the final word.
module s1_scatter #(
  parameter int unsigned N = 1
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic [N-1:0] D,
  input  logic         D_VLD,
  input  logic         D_LAST,
  output logic         D_RDY,
  input  logic         A1,
  input  logic         B1,
  input  logic         A0,
  input  logic         BCAST,
  output logic [N-1:0] Q00,
  output logic [N-1:0] Q01,
  output logic [N-1:0] Q10,
  output logic [N-1:0] Q11,
  output logic [3:0]   Q_VLD,
  input  logic [3:0]   Q_RDY,
  output logic [7:0]   WCNT
);

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, PKT} state_t;

  state_t             state_q, state_d;
  logic               lat_en;
  logic [SEL_W-1:0]   sel_live, sel_lat, eff_sel;
  logic               bcast_lat, eff_bc;
  logic [LANES-1:0]   lane_free, wr, qvld_d;
  logic               accept;
  logic [N-1:0]       lane_q [LANES];

  assign sel_live  = {A1 | B1, A0};
  assign eff_sel   = (state_q == PKT) ? sel_lat : sel_live;
  assign eff_bc    = (state_q == PKT) ? bcast_lat : BCAST;
  assign lane_free = ~Q_VLD | Q_RDY;
  assign D_RDY     = ~CLR & (eff_bc ? (&lane_free) : lane_free[eff_sel]);
  assign accept    = D_VLD & D_RDY;

  // Lane write enables and next valid: a write keeps a draining lane full.
  always_comb begin
    wr = '0;
    for (int i = 0; i < LANES; i++) begin
      wr[i] = accept & (eff_bc | (eff_sel == SEL_W'(i)));
    end
    qvld_d = wr | (Q_VLD & ~Q_RDY);
  end

  always_comb begin
    state_d = state_q;
    lat_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !D_LAST) begin
          state_d = PKT;
          lat_en  = 1'b1;
        end
      end
      PKT: begin
        if (accept && D_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      sel_lat   <= '0;
      bcast_lat <= 1'b0;
      Q_VLD     <= '0;
      WCNT      <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else begin
      state_q <= state_d;
      Q_VLD   <= qvld_d;
      if (lat_en) begin
        sel_lat   <= sel_live;
        bcast_lat <= BCAST;
      end
      if (accept) WCNT <= WCNT + 8'd1;
      for (int i = 0; i < LANES; i++) begin
        if (wr[i]) lane_q[i] <= D;
      end
    end
  end

  assign Q00 = lane_q[0];
  assign Q01 = lane_q[1];
  assign Q10 = lane_q[2];
  assign Q11 = lane_q[3];

endmodule
